// File: rtl/kernel_call_harness.sv
// kernel_call_harness: drives a kernel's start pulse, checks each return value.
// Define KERNEL_CALL_HARNESS_TIMEOUT_EN to build the per-invocation watchdog.
module kernel_call_harness #(
  parameter logic [31:0] EXPECTED     = 32'd0,
  parameter int          RUNS         = 1,
  parameter int          START_CYCLES = 2,
  parameter int          TIMEOUT      = 1000
) (
  input  logic        __clk,
  input  logic        __resetn,
  input  logic        go,
  output logic        k_start,
  input  logic        k_valid,
  input  logic [31:0] k_retval,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        timeout,
  output logic [31:0] last_retval,
  output logic [15:0] err_count,
  output logic [15:0] run_count
);

  if (RUNS < 1 || RUNS > 65535 || START_CYCLES < 1 || TIMEOUT < 2) begin : g_bad_cfg
    $error("kernel_call_harness: illegal parameter set");
  end

  typedef enum logic [2:0] {
    IDLE,
    START,
    WAIT,
    GAP,
    DONE
  } state_t;

  localparam int          SCW     = $clog2(START_CYCLES + 1);
  localparam logic [SCW-1:0] SC_LAST = SCW'(START_CYCLES - 1);
  localparam logic [15:0] RUNS_W  = 16'(RUNS);

  state_t         state, state_d;
  logic [SCW-1:0] scnt, scnt_d;
  logic [31:0]    retval_d;
  logic [15:0]    err_d, run_d;
  logic           pass_d;
  logic           wd_fire;

`ifdef KERNEL_CALL_HARNESS_TIMEOUT_EN
  localparam int             WDW     = $clog2(TIMEOUT + 1);
  localparam logic [WDW-1:0] TO_LAST = WDW'(TIMEOUT - 1);

  logic [WDW-1:0] wd, wd_d;
  logic           to_d;

  assign wd_fire = (wd == TO_LAST);
`else
  assign wd_fire = 1'b0;
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d  = state;
    scnt_d   = scnt;
    retval_d = last_retval;
    err_d    = err_count;
    run_d    = run_count;
    pass_d   = pass;
`ifdef KERNEL_CALL_HARNESS_TIMEOUT_EN
    wd_d     = wd;
    to_d     = timeout;
`endif
    unique case (state)
      IDLE, DONE: begin
        if (go) begin
          state_d = START;
          scnt_d  = '0;
          err_d   = '0;
          run_d   = '0;
          pass_d  = 1'b0;
`ifdef KERNEL_CALL_HARNESS_TIMEOUT_EN
          wd_d    = '0;
          to_d    = 1'b0;
`endif
        end
      end
      START, WAIT: begin
        if (state == START) scnt_d = scnt + SCW'(1);
`ifdef KERNEL_CALL_HARNESS_TIMEOUT_EN
        wd_d = wd + WDW'(1);
`endif
        // a completion wins over both the watchdog and the START hold time
        if (k_valid) begin
          retval_d = k_retval;
          if (k_retval != EXPECTED && err_count != 16'hFFFF)
            err_d = err_count + 16'd1;
          run_d = run_count + 16'd1;
          if (run_d == RUNS_W) begin
            state_d = DONE;
            pass_d  = (err_d == 16'd0) && !timeout;
          end else begin
            state_d = GAP;
          end
        end else if (wd_fire) begin
          state_d = DONE;
          pass_d  = 1'b0;
`ifdef KERNEL_CALL_HARNESS_TIMEOUT_EN
          to_d    = 1'b1;
`endif
        end else if (state == START && scnt == SC_LAST) begin
          state_d = WAIT;
        end
      end
      GAP: begin
        state_d = START;
        scnt_d  = '0;
`ifdef KERNEL_CALL_HARNESS_TIMEOUT_EN
        wd_d    = '0;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge __clk or negedge __resetn) begin
    if (!__resetn) begin
      state       <= IDLE;
      scnt        <= '0;
      k_start     <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
      last_retval <= '0;
      err_count   <= '0;
      run_count   <= '0;
    end else begin
      state       <= state_d;
      scnt        <= scnt_d;
      k_start     <= (state_d == START);
      busy        <= (state_d == START) || (state_d == WAIT) ||
                     (state_d == GAP);
      done        <= (state_d == DONE);
      pass        <= pass_d;
      last_retval <= retval_d;
      err_count   <= err_d;
      run_count   <= run_d;
    end
  end

`ifdef KERNEL_CALL_HARNESS_TIMEOUT_EN
  always_ff @(posedge __clk or negedge __resetn) begin
    if (!__resetn) begin
      wd      <= '0;
      timeout <= 1'b0;
    end else begin
      wd      <= wd_d;
      timeout <= to_d;
    end
  end
`endif

endmodule

// File: tb/tb_kernel_call_harness.sv
// tb_kernel_call_harness: randomized kernel model with queued expectations.
// Watchdog expectations follow KERNEL_CALL_HARNESS_TIMEOUT_EN.
module tb_kernel_call_harness;

  localparam logic [31:0] EXP_P  = 32'd42;
  localparam int          RUNS_P = 3;
  localparam int          SC_P   = 3;
  localparam int          TO_P   = 20;

  typedef struct {
    int          lat;
    logic [31:0] ret;
    bit          last;
  } call_t;

  typedef struct {
    int          run;
    int          err;
    bit          pass;
    bit          to;
    logic [31:0] last;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        go;
  logic        k_start;
  logic        k_valid;
  logic [31:0] k_retval;
  logic        busy;
  logic        done;
  logic        pass;
  logic        timeout;
  logic [31:0] last_retval;
  logic [15:0] err_count;
  logic [15:0] run_count;
  logic        kv_model = 1'b0;
  logic        spur = 1'b0;

  int checks = 0;
  int errors = 0;

  call_t       plan_q[$];
  int          hi_q[$];
  exp_t        exp_q[$];
  logic [31:0] model_last = 32'd0;
  int          s_lat[RUNS_P];
  logic [31:0] s_ret[RUNS_P];

  always #5 clk = ~clk;
  assign k_valid = kv_model | spur;

  kernel_call_harness #(
    .EXPECTED(EXP_P),
    .RUNS(RUNS_P),
    .START_CYCLES(SC_P),
    .TIMEOUT(TO_P)
  ) dut (
    .__clk(clk),
    .__resetn(rst_n),
    .go(go),
    .k_start(k_start),
    .k_valid(k_valid),
    .k_retval(k_retval),
    .busy(busy),
    .done(done),
    .pass(pass),
    .timeout(timeout),
    .last_retval(last_retval),
    .err_count(err_count),
    .run_count(run_count)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // kernel model: answers each k_start rise after the planned latency
  call_t kc;
  bit    k_act;
  int    k_cnt;
  bit    prev_ks;
  bit    gap_arm;
  int    gap_cnt;

  always @(negedge clk) begin
    kv_model = 1'b0;
    k_retval = $urandom;
    if (!rst_n) begin
      k_act   = 1'b0;
      prev_ks = 1'b0;
      gap_arm = 1'b0;
    end else begin
      if (gap_arm) gap_cnt++;
      if (k_start && !prev_ks) begin
        if (gap_arm) begin
          chk("gap_cycles", gap_cnt, 2);
          gap_arm = 1'b0;
        end
        if (plan_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL kernel_plan: k_start rose with no call planned");
          k_act = 1'b0;
        end else begin
          kc    = plan_q.pop_front();
          k_act = 1'b1;
          k_cnt = 0;
        end
      end else if (k_act) begin
        k_cnt++;
      end
      if (k_act && kc.lat == k_cnt) begin
        kv_model = 1'b1;
        k_retval = kc.ret;
        k_act    = 1'b0;
        if (!kc.last) begin
          gap_arm = 1'b1;
          gap_cnt = 0;
        end
      end
      prev_ks = k_start;
    end
  end

  int hi_cnt;

  always @(negedge clk) begin
    if (!rst_n) begin
      hi_cnt = 0;
    end else if (k_start) begin
      hi_cnt++;
    end else if (hi_cnt > 0) begin
      if (hi_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL start_len: unplanned pulse of %0d cycles", hi_cnt);
      end else begin
        chk("start_len", hi_cnt, hi_q.pop_front());
      end
      hi_cnt = 0;
    end
  end

  exp_t mon_e;
  bit   prev_done;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_done = 1'b0;
    end else begin
      if (done && !prev_done) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL seq_unexpected: done=1 with no sequence pending");
        end else begin
          mon_e = exp_q.pop_front();
          chk("seq_run", run_count, mon_e.run);
          chk("seq_err", err_count, mon_e.err);
          chk("seq_pass", pass, mon_e.pass);
          chk("seq_timeout", timeout, mon_e.to);
          chk("seq_last", last_retval, mon_e.last);
          chk("seq_busy", busy, 0);
        end
      end
      prev_done = done;
    end
  end

  task automatic do_reset(input bit check);
    @(negedge clk);
    #2 rst_n = 1'b0;
    go = 1'b0;
    #1;
    if (check) begin
      chk("rst_k_start", k_start, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_pass", pass, 0);
      chk("rst_timeout", timeout, 0);
      chk("rst_last", last_retval, 0);
      chk("rst_err", err_count, 0);
      chk("rst_run", run_count, 0);
    end
    plan_q.delete();
    hi_q.delete();
    exp_q.delete();
    model_last = 32'd0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run_seq(input int never_at);
    exp_t  e;
    call_t c;
    int    n;
    int    cyc;
    n      = (never_at >= 0) ? never_at + 1 : RUNS_P;
    e.run  = 0;
    e.err  = 0;
    e.last = model_last;
    for (int i = 0; i < n; i++) begin
      c.lat  = (i == never_at) ? -1 : s_lat[i];
      c.ret  = s_ret[i];
      c.last = (i == n - 1);
      plan_q.push_back(c);
      hi_q.push_back((c.lat < 0 || c.lat >= SC_P) ? SC_P : c.lat + 1);
      if (c.lat >= 0) begin
        e.run++;
        if (c.ret != EXP_P) e.err++;
        e.last = c.ret;
      end
    end
    e.to   = (never_at >= 0);
    e.pass = (e.err == 0) && !e.to;
`ifdef KERNEL_CALL_HARNESS_TIMEOUT_EN
    exp_q.push_back(e);
`else
    if (!e.to) exp_q.push_back(e);
`endif
    @(negedge clk);
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    chk("go_k_start", k_start, 1);
    chk("go_busy", busy, 1);
    cyc = 1;
`ifndef KERNEL_CALL_HARNESS_TIMEOUT_EN
    if (e.to) begin
      repeat (1000) begin
        @(negedge clk);
        go = busy && ($urandom_range(0, 7) == 0);
      end
      go = 1'b0;
      chk("nowd_busy", busy, 1);
      chk("nowd_done", done, 0);
      do_reset(0);
      return;
    end
`endif
    while (!done && cyc < 400) begin
      @(negedge clk);
      cyc++;
      go = busy && ($urandom_range(0, 7) == 0);
    end
    go = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL seq_done: done=0 after %0d cycles, required 1", cyc);
      do_reset(0);
      return;
    end
`ifdef KERNEL_CALL_HARNESS_TIMEOUT_EN
    if (e.to && never_at == 0) chk("wd_latency", cyc, TO_P + 1);
`endif
    model_last = e.last;
    @(negedge clk);
    spur = 1'b1;
    @(negedge clk);
    spur = 1'b0;
    chk("done_hold", done, 1);
    chk("done_ign_run", run_count, e.run);
    chk("done_ign_last", last_retval, e.last);
  endtask

  initial begin
    call_t c;
    rst_n = 1'b0;
    go    = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    do_reset(1);

    s_lat = '{5, 5, 5};
    s_ret = '{32'd42, 32'd42, 32'd42};
    run_seq(-1);
    s_lat = '{4, 2, 6};
    s_ret = '{32'd42, 32'd7, 32'd42};
    run_seq(-1);
    s_lat = '{1, 0, 2};
    s_ret = '{32'd42, 32'd42, 32'd42};
    run_seq(-1);

    for (int s = 0; s < 20; s++) begin
      for (int i = 0; i < RUNS_P; i++) begin
        s_lat[i] = $urandom_range(0, 9);
        s_ret[i] = ($urandom_range(0, 3) == 0) ? $urandom : EXP_P;
      end
      run_seq(-1);
    end

    s_lat = '{3, 3, 3};
    s_ret = '{32'd42, 32'd42, 32'd42};
    run_seq(0);
`ifdef KERNEL_CALL_HARNESS_TIMEOUT_EN
    s_ret = '{32'd9, 32'd42, 32'd42};
    run_seq(1);
    s_ret = '{32'd42, 32'd42, 32'd42};
    run_seq(-1);
`endif

    c.lat  = -1;
    c.ret  = 32'd0;
    c.last = 1'b1;
    plan_q.push_back(c);
    hi_q.push_back(SC_P);
    @(negedge clk);
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    repeat (SC_P + 2) @(negedge clk);
    chk("wait_busy", busy, 1);
    chk("wait_k_start", k_start, 0);
    do_reset(1);
    s_lat = '{2, 7, 1};
    s_ret = '{32'd42, 32'd42, 32'd42};
    run_seq(-1);

    repeat (5) @(negedge clk);
    chk("drain_exp", exp_q.size(), 0);
    chk("drain_plan", plan_q.size(), 0);
    chk("drain_hi", hi_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL sim_limit: bench did not reach its end by 500000 ns");
    $fatal(1, "simulation time limit");
  end

endmodule
